// File: rtl/iir_pasobajo_seq.sv
// iir_pasobajo_seq: sequential direct-form-I biquad, one shared multiplier, one term per clock
module iir_pasobajo_seq #(
    parameter int cant_bits = 25,
    parameter int frac_bits = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [cant_bits-1:0] x_in_i,
    input  logic [cant_bits-1:0] cte_i,
    output logic [3:0]           sel_cte_o,
    output logic [cant_bits-1:0] y_out_o,
    output logic                 done_o,
    output logic                 busy_o
);
    localparam int prod_bits = 2 * cant_bits;
    localparam int acc_bits = prod_bits + 3;
    localparam logic signed [acc_bits-1:0] y_max = acc_bits'(2 ** (cant_bits - 1) - 1);
    localparam logic signed [acc_bits-1:0] y_min = -y_max - 1;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state_q;
    logic signed [cant_bits-1:0] x0_q, x1_q, x2_q, y1_q, y2_q, mul_d, y_d;
    logic signed [prod_bits-1:0] prod_d;
    logic signed [acc_bits-1:0] acc_q, acc_d, r_d;
    logic [2:0] k_q;
    // operand select, shared multiply-accumulate and saturating rescale of the sum
    always_comb begin
        mul_d = k_q == 3'd0 ? x0_q : k_q == 3'd1 ? x1_q : k_q == 3'd2 ? x2_q : k_q == 3'd3 ? y1_q : y2_q;
        prod_d = $signed(cte_i) * mul_d;
        acc_d = acc_q + {{(acc_bits - prod_bits){prod_d[prod_bits-1]}}, prod_d};
        r_d = acc_q >>> frac_bits;
        y_d = r_d > y_max ? y_max[cant_bits-1:0] : r_d < y_min ? y_min[cant_bits-1:0] : r_d[cant_bits-1:0];
    end
    // FSM: capture sample, accumulate five terms, then publish result and shift delay lines
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            sel_cte_o <= '0;
            y_out_o   <= '0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_o <= 1'b0;
                    busy_o <= start_i;
                    if (start_i) begin
                        x0_q      <= x_in_i;
                        acc_q     <= '0;
                        k_q       <= '0;
                        sel_cte_o <= 4'd5;
                        state_q   <= MAC;
                    end
                end
                MAC: begin
                    acc_q     <= acc_d;
                    k_q       <= k_q + 3'd1;
                    sel_cte_o <= k_q == 3'd0 ? 4'd6 : k_q == 3'd1 ? 4'd7 : k_q == 3'd2 ? 4'd1 : k_q == 3'd3 ? 4'd2 : 4'd0;
                    if (k_q == 3'd4) state_q <= OUT;
                end
                OUT: begin
                    y_out_o <= y_d;
                    y1_q    <= y_d;
                    y2_q    <= y1_q;
                    x1_q    <= x0_q;
                    x2_q    <= x1_q;
                    done_o  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
